// File: rtl/mem_bus_pkg.sv
// Shared types for the two-master SRAM/MMIO bus arbiter.
// FSM states, address regions and the default unmapped read pattern.
package mem_bus_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RAM,
      S_RAM_WAIT,
      S_IO_WAIT,
      S_DONE
   } state_t;

   typedef enum logic [1:0] {
      REG_RAM,
      REG_IO,
      REG_NONE
   } region_t;

   localparam logic [31:0] UNMAPPED_RDATA_DEF = 32'hDEAD_BEEF;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the pointer remembers the last winner
// and the other requester wins a tie. Pointer resets to m1.
module rr_arb2
   import mem_bus_pkg::*;
(
   input  logic       clk,
   input  logic       resetn,
   input  logic [1:0] req,
   input  logic       advance,
   output logic [1:0] gnt,
   output logic       last
);

   always_comb begin
      gnt = 2'b00;
      unique case (req)
         2'b01:   gnt = 2'b01;
         2'b10:   gnt = 2'b10;
         2'b11:   gnt = last ? 2'b01 : 2'b10;
         default: gnt = 2'b00;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)
         last <= 1'b1;
      else if (advance && (gnt != 2'b00))
         last <= gnt[1];
   end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares SRAM and the MMIO window between two picorv32-native masters,
// one transaction at a time, with address decode and registered outputs.
module mem_bus_arbiter
   import mem_bus_pkg::*;
#(
   parameter int          MEM_SIZE       = 4096,
   parameter int          RAM_RD_LAT     = 2,
   parameter logic [31:0] MMIO_BASE      = 32'h0000_4000,
   parameter int          MMIO_WORDS     = 4,
   parameter int          IO_TIMEOUT     = 255,
   parameter logic [31:0] UNMAPPED_RDATA = UNMAPPED_RDATA_DEF
)(
   input  logic                          clk,
   input  logic                          resetn,
   input  logic                          m0_valid,
   input  logic [31:0]                   m0_addr,
   input  logic [31:0]                   m0_wdata,
   input  logic [3:0]                    m0_wstrb,
   output logic                          m0_ready,
   output logic [31:0]                   m0_rdata,
   input  logic                          m1_valid,
   input  logic [31:0]                   m1_addr,
   input  logic [31:0]                   m1_wdata,
   input  logic [3:0]                    m1_wstrb,
   output logic                          m1_ready,
   output logic [31:0]                   m1_rdata,
   output logic                          ram_en,
   output logic [3:0]                    ram_we,
   output logic [$clog2(MEM_SIZE)-1:0]   ram_addr,
   output logic [31:0]                   ram_wdata,
   input  logic [31:0]                   ram_rdata,
   output logic                          io_valid,
   output logic [$clog2(MMIO_WORDS)-1:0] io_addr,
   output logic [31:0]                   io_wdata,
   output logic [3:0]                    io_wstrb,
   input  logic                          io_ready,
   input  logic [31:0]                   io_rdata,
   output logic [1:0]                    grant,
   output logic                          bus_err
);

   localparam int          AW      = $clog2(MEM_SIZE);
   localparam int          IW      = $clog2(MMIO_WORDS);
   localparam logic [31:0] IO_END  = MMIO_BASE + 32'(4 * MMIO_WORDS);
   localparam logic [7:0]  TO_LAST = (IO_TIMEOUT > 256) ? 8'hFF
                                                        : 8'(IO_TIMEOUT - 1);

   state_t            state_q, state_d;
   region_t           region_q, region_d, sel_reg;
   logic [1:0]        grant_q, grant_d, gnt;
   logic              wr_q, wr_d, arb_last;
   logic [2:0]        cnt_q, cnt_d;
   logic [7:0]        tcnt_q, tcnt_d;
   logic [31:0]       rdata_q, rdata_d;
   logic [1:0]        ready_q, ready_d;
   logic              err_q, err_d;
   logic              ram_en_q, ram_en_d;
   logic [3:0]        ram_we_q, ram_we_d;
   logic [AW-1:0]     ram_addr_q, ram_addr_d;
   logic [31:0]       ram_wdata_q, ram_wdata_d;
   logic              io_valid_q, io_valid_d;
   logic [IW-1:0]     io_addr_q, io_addr_d;
   logic [31:0]       io_wdata_q, io_wdata_d;
   logic [3:0]        io_wstrb_q, io_wstrb_d;
   logic [31:0]       sel_addr, sel_wdata;
   logic [3:0]        sel_wstrb;
   logic              idle;

   assign idle = (state_q == S_IDLE);

   rr_arb2 u_arb (
      .clk     (clk),
      .resetn  (resetn),
      .req     (idle ? {m1_valid, m0_valid} : 2'b00),
      .advance (idle),
      .gnt     (gnt),
      .last    (arb_last)
   );

   assign sel_addr  = gnt[1] ? m1_addr  : m0_addr;
   assign sel_wdata = gnt[1] ? m1_wdata : m0_wdata;
   assign sel_wstrb = gnt[1] ? m1_wstrb : m0_wstrb;

   // RAM wins if the windows ever overlap
   always_comb begin
      if ((sel_addr >> 2) < 32'(MEM_SIZE))
         sel_reg = REG_RAM;
      else if (sel_addr >= MMIO_BASE && sel_addr < IO_END)
         sel_reg = REG_IO;
      else
         sel_reg = REG_NONE;
   end

   always_comb begin
      state_d     = state_q;
      region_d    = region_q;
      grant_d     = grant_q;
      wr_d        = wr_q;
      cnt_d       = cnt_q;
      tcnt_d      = tcnt_q;
      rdata_d     = rdata_q;
      ready_d     = 2'b00;
      err_d       = 1'b0;
      ram_en_d    = 1'b0;
      ram_we_d    = 4'b0000;
      ram_addr_d  = ram_addr_q;
      ram_wdata_d = ram_wdata_q;
      io_valid_d  = io_valid_q;
      io_addr_d   = io_addr_q;
      io_wdata_d  = io_wdata_q;
      io_wstrb_d  = io_wstrb_q;
      unique case (state_q)
         S_IDLE: begin
            if (gnt != 2'b00) begin
               grant_d  = gnt;
               region_d = sel_reg;
               wr_d     = (sel_wstrb != 4'b0000);
               cnt_d    = 3'd0;
               tcnt_d   = 8'd0;
               unique case (sel_reg)
                  REG_RAM: begin
                     ram_en_d    = 1'b1;
                     ram_we_d    = sel_wstrb;
                     ram_addr_d  = AW'(sel_addr >> 2);
                     ram_wdata_d = sel_wdata;
                     state_d     = S_RAM;
                  end
                  REG_IO: begin
                     io_valid_d = 1'b1;
                     io_addr_d  = IW'((sel_addr - MMIO_BASE) >> 2);
                     io_wdata_d = sel_wdata;
                     io_wstrb_d = sel_wstrb;
                     state_d    = S_IO_WAIT;
                  end
                  default: state_d = S_RAM;
               endcase
            end
         end
         // unmapped accesses also pass through here for N+2 timing
         S_RAM: begin
            if (region_q == REG_NONE) begin
               rdata_d = UNMAPPED_RDATA;
               err_d   = 1'b1;
               ready_d = grant_q;
               state_d = S_DONE;
            end else if (wr_q) begin
               ready_d = grant_q;
               state_d = S_DONE;
            end else begin
               cnt_d   = 3'd1;
               state_d = S_RAM_WAIT;
            end
         end
         S_RAM_WAIT: begin
            if (cnt_q == 3'(RAM_RD_LAT)) begin
               rdata_d = ram_rdata;
               ready_d = grant_q;
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q + 3'd1;
            end
         end
         S_IO_WAIT: begin
            if (io_ready) begin
               io_valid_d = 1'b0;
               rdata_d    = io_rdata;
               ready_d    = grant_q;
               state_d    = S_DONE;
            end else if (tcnt_q >= TO_LAST) begin
               io_valid_d = 1'b0;
               rdata_d    = UNMAPPED_RDATA;
               err_d      = 1'b1;
               ready_d    = grant_q;
               state_d    = S_DONE;
            end else if (tcnt_q != 8'hFF) begin
               tcnt_d = tcnt_q + 8'd1;
            end
         end
         S_DONE: begin
            grant_d = 2'b00;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q     <= S_IDLE;
         region_q    <= REG_RAM;
         grant_q     <= 2'b00;
         wr_q        <= 1'b0;
         cnt_q       <= 3'd0;
         tcnt_q      <= 8'd0;
         rdata_q     <= 32'd0;
         ready_q     <= 2'b00;
         err_q       <= 1'b0;
         ram_en_q    <= 1'b0;
         ram_we_q    <= 4'b0000;
         ram_addr_q  <= '0;
         ram_wdata_q <= 32'd0;
         io_valid_q  <= 1'b0;
         io_addr_q   <= '0;
         io_wdata_q  <= 32'd0;
         io_wstrb_q  <= 4'b0000;
      end else begin
         state_q     <= state_d;
         region_q    <= region_d;
         grant_q     <= grant_d;
         wr_q        <= wr_d;
         cnt_q       <= cnt_d;
         tcnt_q      <= tcnt_d;
         rdata_q     <= rdata_d;
         ready_q     <= ready_d;
         err_q       <= err_d;
         ram_en_q    <= ram_en_d;
         ram_we_q    <= ram_we_d;
         ram_addr_q  <= ram_addr_d;
         ram_wdata_q <= ram_wdata_d;
         io_valid_q  <= io_valid_d;
         io_addr_q   <= io_addr_d;
         io_wdata_q  <= io_wdata_d;
         io_wstrb_q  <= io_wstrb_d;
      end
   end

   assign m0_ready  = ready_q[0];
   assign m1_ready  = ready_q[1];
   assign m0_rdata  = rdata_q;
   assign m1_rdata  = rdata_q;
   assign ram_en    = ram_en_q;
   assign ram_we    = ram_we_q;
   assign ram_addr  = ram_addr_q;
   assign ram_wdata = ram_wdata_q;
   assign io_valid  = io_valid_q;
   assign io_addr   = io_addr_q;
   assign io_wdata  = io_wdata_q;
   assign io_wstrb  = io_wstrb_q;
   assign grant     = grant_q;
   assign bus_err   = err_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed plus randomized bench for mem_bus_arbiter, checked against
// a transaction-level model (byte-merged memory, latency rules, RR pointer).
module tb_mem_bus_arbiter;

   localparam int L = 2;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        m0_valid = 1'b0, m1_valid = 1'b0;
   logic [31:0] m0_addr = '0, m1_addr = '0;
   logic [31:0] m0_wdata = '0, m1_wdata = '0;
   logic [3:0]  m0_wstrb = '0, m1_wstrb = '0;
   logic        m0_ready, m1_ready;
   logic [31:0] m0_rdata, m1_rdata;
   logic        ram_en;
   logic [3:0]  ram_we;
   logic [11:0] ram_addr;
   logic [31:0] ram_wdata, ram_rdata;
   logic        io_valid;
   logic [1:0]  io_addr;
   logic [31:0] io_wdata;
   logic [3:0]  io_wstrb;
   logic        io_ready = 1'b0;
   logic [31:0] io_rdata = '0;
   logic [1:0]  grant;
   logic        bus_err;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   int last_winner = 1;
   int io_delay_cfg = 0;
   int io_cnt = 0;
   logic [31:0] io_seen_wdata;
   logic [3:0]  io_seen_wstrb;
   logic [1:0]  io_seen_addr;

   logic [31:0] sram    [0:4095];
   logic [31:0] ref_mem [0:4095];
   logic [31:0] pipe    [0:L-1];

   mem_bus_arbiter dut (
      .clk(clk), .resetn(resetn),
      .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_wstrb(m0_wstrb), .m0_ready(m0_ready), .m0_rdata(m0_rdata),
      .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_wstrb(m1_wstrb), .m1_ready(m1_ready), .m1_rdata(m1_rdata),
      .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
      .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
      .io_valid(io_valid), .io_addr(io_addr), .io_wdata(io_wdata),
      .io_wstrb(io_wstrb), .io_ready(io_ready), .io_rdata(io_rdata),
      .grant(grant), .bus_err(bus_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // SRAM model: read data appears L cycles after ram_en, junk otherwise
   always @(posedge clk) begin
      if (ram_en && ram_we != 4'b0000)
         for (int b = 0; b < 4; b++)
            if (ram_we[b]) sram[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
      for (int i = L - 1; i > 0; i--) pipe[i] <= pipe[i-1];
      pipe[0] <= (ram_en && ram_we == 4'b0000) ? sram[ram_addr] : 32'h5A5A_5A5A;
   end
   assign ram_rdata = pipe[L-1];

   // MMIO responder: io_ready on the io_delay_cfg-th io_valid cycle (0 = never)
   always @(negedge clk) begin
      if (io_valid) begin
         io_cnt++;
         io_ready = (io_cnt == io_delay_cfg);
         io_rdata = 32'hC0DE_0000 | 32'(io_addr);
         if (io_ready) begin
            io_seen_wdata = io_wdata;
            io_seen_wstrb = io_wstrb;
            io_seen_addr  = io_addr;
         end
      end else begin
         io_cnt   = 0;
         io_ready = 1'b0;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] wd, logic [3:0] s);
      for (int b = 0; b < 4; b++)
         if (s[b]) old[8*b +: 8] = wd[8*b +: 8];
      return old;
   endfunction

   // 0 = RAM, 1 = MMIO, 2 = unmapped
   function automatic int region(logic [31:0] a);
      if ((a >> 2) < 32'd4096) return 0;
      if (a >= 32'h4000 && a < 32'h4010) return 1;
      return 2;
   endfunction

   task automatic drive(input int m, input logic v, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] ws);
      if (m == 0) begin
         m0_valid = v; m0_addr = a; m0_wdata = wd; m0_wstrb = ws;
      end else begin
         m1_valid = v; m1_addr = a; m1_wdata = wd; m1_wstrb = ws;
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_ctl"}, 32'({ram_en, ram_we, io_valid, grant, bus_err, m0_ready, m1_ready}), 32'd0);
      chk({tag, "_addr"}, 32'({ram_addr, io_addr}), 32'd0);
      chk({tag, "_data"}, ram_wdata | io_wdata | m0_rdata | m1_rdata | 32'(io_wstrb), 32'd0);
   endtask

   task automatic txn(input int m, input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] ws, input int iod);
      int n, lat, n_en, n_io, t_en, t_done, rg, exp_io;
      logic [31:0] exp_rd;
      logic exp_err, done;
      rg = region(a);
      n_en = 0; n_io = 0; t_en = -1; t_done = -1; done = 1'b0;
      exp_err = 1'b0; exp_rd = 32'hDEAD_BEEF; exp_io = 0; lat = 2;
      io_delay_cfg = iod;
      if (rg == 0) begin
         lat = (ws != 4'b0) ? 2 : 2 + L;
         exp_rd = ref_mem[a[13:2]];
         if (ws != 4'b0) ref_mem[a[13:2]] = merge(ref_mem[a[13:2]], wd, ws);
      end else if (rg == 1) begin
         if (iod == 0) begin
            lat = 256; exp_io = 255; exp_err = 1'b1;
         end else begin
            lat = iod + 1; exp_io = iod;
            exp_rd = 32'hC0DE_0000 | ((a - 32'h4000) >> 2);
         end
      end else begin
         exp_err = 1'b1;
      end
      @(negedge clk);
      drive(m, 1'b1, a, wd, ws);
      n = cyc;
      for (int k = 0; k < 400 && !done; k++) begin
         @(negedge clk);
         if (ram_en) begin n_en++; t_en = cyc; end
         if (io_valid) n_io++;
         if (m0_ready || m1_ready) begin
            done = 1'b1; t_done = cyc;
            chk("ready_owner", 32'({m1_ready, m0_ready}), (m == 1) ? 32'd2 : 32'd1);
            chk("grant", 32'(grant), (m == 1) ? 32'd2 : 32'd1);
            chk("bus_err", 32'(bus_err), 32'(exp_err));
            if (ws == 4'b0) chk("rdata", (m == 1) ? m1_rdata : m0_rdata, exp_rd);
         end
      end
      drive(m, 1'b0, 32'd0, 32'd0, 4'd0);
      chk("done", 32'(done), 32'd1);
      chk("latency", 32'(t_done - n), 32'(lat));
      chk("ram_en_cnt", 32'(n_en), 32'(rg == 0));
      if (rg == 0) chk("ram_en_cyc", 32'(t_en - n), 32'd1);
      chk("io_valid_cnt", 32'(n_io), 32'(exp_io));
      if (rg == 1 && iod != 0 && ws != 4'b0) begin
         chk("io_wdata", io_seen_wdata, wd);
         chk("io_wstrb", 32'(io_seen_wstrb), 32'(ws));
         chk("io_addr", 32'(io_seen_addr), (a - 32'h4000) >> 2);
      end
      last_winner = m;
      @(negedge clk);
      chk("grant_clr", 32'(grant), 32'd0);
   endtask

   // both masters request RAM in the same IDLE cycle
   task automatic pair(input logic [31:0] a0, input logic [31:0] d0, input logic [3:0] s0,
                       input logic [31:0] a1, input logic [31:0] d1, input logic [3:0] s1);
      logic [31:0] a [2], wd [2], exp_rd [2], rd [2];
      logic [3:0]  ws [2];
      int lat [2], t [2], tex [2];
      int n, f, s, got, x;
      a[0] = a0; a[1] = a1; wd[0] = d0; wd[1] = d1; ws[0] = s0; ws[1] = s1;
      f = (last_winner == 1) ? 0 : 1;
      s = 1 - f;
      foreach (lat[i]) begin
         x = (i == 0) ? f : s;
         lat[x] = (ws[x] != 4'b0) ? 2 : 2 + L;
         exp_rd[x] = ref_mem[a[x][13:2]];
         if (ws[x] != 4'b0) ref_mem[a[x][13:2]] = merge(ref_mem[a[x][13:2]], wd[x], ws[x]);
      end
      @(negedge clk);
      drive(0, 1'b1, a0, d0, s0);
      drive(1, 1'b1, a1, d1, s1);
      n = cyc;
      tex[f] = n + lat[f];
      tex[s] = tex[f] + 1 + lat[s];
      t[0] = -1; t[1] = -1; got = 0;
      for (int k = 0; k < 100 && got < 2; k++) begin
         @(negedge clk);
         if (m0_ready || m1_ready) begin
            chk("pair_onehot", 32'($countones({m1_ready, m0_ready})), 32'd1);
            x = m1_ready ? 1 : 0;
            t[x] = cyc;
            rd[x] = (x == 1) ? m1_rdata : m0_rdata;
            if (got == 0) chk("pair_first", 32'(x), 32'(f));
            got++;
            drive(x, 1'b0, 32'd0, 32'd0, 4'd0);
         end
      end
      drive(0, 1'b0, 32'd0, 32'd0, 4'd0);
      drive(1, 1'b0, 32'd0, 32'd0, 4'd0);
      chk("pair_done", 32'(got), 32'd2);
      for (int i = 0; i < 2; i++) begin
         chk("pair_cycle", 32'(t[i]), 32'(tex[i]));
         if (ws[i] == 4'b0) chk("pair_rdata", rd[i], exp_rd[i]);
      end
      last_winner = s;
      @(negedge clk);
      chk("pair_grant_clr", 32'(grant), 32'd0);
   endtask

   initial begin
      logic [31:0] ra, wd;
      logic [3:0]  ws;
      int m, kind, iod;
      logic [31:0] unm [4];
      unm[0] = 32'h4010; unm[1] = 32'h8000; unm[2] = 32'hFFFF_FFFC; unm[3] = 32'h4020;
      for (int i = 0; i < 4096; i++) begin
         sram[i] = 32'd0;
         ref_mem[i] = 32'd0;
      end
      for (int i = 0; i < L; i++) pipe[i] = 32'd0;

      repeat (3) @(negedge clk);
      chk_zero("reset");
      resetn = 1'b1;
      last_winner = 1;

      for (int i = 0; i < 4; i++)
         pair(32'h100 + 32'(8 * i), $urandom, 4'hF, 32'h104 + 32'(8 * i), $urandom, 4'h0);

      txn(0, 32'h10, 32'h1234_5678, 4'hF, 0);
      txn(0, 32'h10, 32'd0, 4'h0, 0);
      txn(1, 32'h4000, 32'h1, 4'hF, 3);
      txn(0, 32'h4000, 32'd0, 4'h0, 0);
      txn(0, 32'h3FFC, 32'hCAFE_F00D, 4'hF, 0);
      txn(0, 32'h3FFC, 32'd0, 4'h0, 0);
      txn(1, 32'h4010, 32'd0, 4'h0, 0);
      txn(1, 32'h4010, 32'h55, 4'hF, 0);
      txn(0, 32'h10, 32'hAABB_CCDD, 4'b0101, 0);
      txn(1, 32'h10, 32'd0, 4'h0, 0);

      for (int i = 0; i < 40; i++) begin
         m    = int'($urandom_range(0, 1));
         kind = int'($urandom_range(0, 9));
         wd   = $urandom;
         ws   = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
         iod  = 0;
         if (kind < 6) begin
            ra = (kind == 5) ? 32'h3FFC : 32'($urandom_range(0, 31)) << 2;
         end else if (kind < 8) begin
            ra  = 32'h4000 + (32'($urandom_range(0, 3)) << 2);
            iod = int'($urandom_range(1, 6));
         end else begin
            ra = unm[$urandom_range(0, 3)];
         end
         txn(m, ra, wd, ws, iod);
         if (i % 4 == 0)
            pair(32'($urandom_range(0, 31)) << 2, $urandom, 4'($urandom_range(0, 15)),
                 32'($urandom_range(0, 31)) << 2, $urandom, 4'($urandom_range(0, 15)));
      end

      @(negedge clk);
      drive(0, 1'b1, 32'h10, 32'd0, 4'h0);
      repeat (2) @(negedge clk);
      chk("pre_reset_grant", 32'(grant), 32'd1);
      resetn = 1'b0;
      #1;
      chk_zero("mid_reset");
      drive(0, 1'b0, 32'd0, 32'd0, 4'h0);
      repeat (2) @(negedge clk);
      resetn = 1'b1;
      last_winner = 1;
      txn(0, 32'h10, 32'd0, 4'h0, 0);
      pair(32'h20, 32'd0, 4'h0, 32'h24, 32'd0, 4'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
